// File: rtl/mem_access.sv
// MEM pipeline stage: data-memory handshake FSM with a timeout, plus the MEM/WB register.
// Optional build macro MEM_MISALIGN_CHECK_EN rejects loads and stores to non-word-aligned addresses.
module mem_access #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  wb_entrada,
  input  logic [2:0]  m_entrada,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        zero,
  input  logic [4:0]  ex_mem_register_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [1:0]  wb_salida,
  output logic [31:0] read_data,
  output logic [31:0] alu_out,
  output logic [4:0]  mem_wb_register_rd,
  output logic        mem_error
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_MAX - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  pend_wb;
  logic [31:0] pend_alu;
  logic [31:0] pend_data;
  logic [4:0]  pend_rd;
  logic        pend_write;
  logic        pend_kill;

  logic mem_op;
  logic is_write;
  logic misaligned;

  // A set mem_write wins over mem_read, so a double-flagged access is a store.
  assign mem_op   = m_entrada[1] | m_entrada[0];
  assign is_write = m_entrada[0];
  assign pc_src   = m_entrada[2] & zero;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      dmem_req           <= 1'b0;
      dmem_we            <= 1'b0;
      dmem_addr          <= '0;
      dmem_wdata         <= '0;
      stall              <= 1'b0;
      mem_error          <= 1'b0;
      wb_salida          <= '0;
      read_data          <= '0;
      alu_out            <= '0;
      mem_wb_register_rd <= '0;
      pend_wb            <= '0;
      pend_alu           <= '0;
      pend_data          <= '0;
      pend_rd            <= '0;
      pend_write         <= 1'b0;
      pend_kill          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            // Snapshot the instruction so DONE retires it even if EX/MEM moves on.
            pend_wb    <= wb_entrada;
            pend_alu   <= alu_result;
            pend_rd    <= ex_mem_register_rd;
            pend_write <= is_write;
            pend_data  <= '0;
            wait_cnt   <= '0;
            wb_salida  <= 2'b00;
            if (misaligned) begin
              mem_error <= 1'b1;
              pend_kill <= 1'b1;
              state     <= DONE;
            end else begin
              pend_kill  <= 1'b0;
              dmem_req   <= 1'b1;
              dmem_addr  <= alu_result;
              dmem_wdata <= write_data;
              dmem_we    <= is_write;
              stall      <= 1'b1;
              state      <= WAIT;
            end
          end else begin
            wb_salida          <= wb_entrada;
            read_data          <= '0;
            alu_out            <= alu_result;
            mem_wb_register_rd <= ex_mem_register_rd;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (dmem_ack || (wait_cnt == LAST_WAIT)) begin
            pend_data <= dmem_ack ? dmem_rdata : 32'd0;
            mem_error <= mem_error | ~dmem_ack;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            stall     <= 1'b0;
            state     <= DONE;
          end
        end

        DONE: begin
          wb_salida          <= pend_kill ? 2'b00 : {pend_wb[1] & ~pend_write, pend_wb[0]};
          read_data          <= pend_data;
          alu_out            <= pend_alu;
          mem_wb_register_rd <= pend_rd;
          state              <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected MEM/WB contents are queued at issue and
// compared when the stage retires the instruction.
module tb_mem_access;

  localparam int WAIT_MAX = 15;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  wb_entrada;
  logic [2:0]  m_entrada;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        zero;
  logic [4:0]  ex_mem_register_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic        pc_src;
  logic [1:0]  wb_salida;
  logic [31:0] read_data;
  logic [31:0] alu_out;
  logic [4:0]  mem_wb_register_rd;
  logic        mem_error;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] data;
    logic [31:0] alu;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   total_checks = 0;
  int   passed_checks = 0;

  mem_access #(.WAIT_MAX(WAIT_MAX)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .wb_entrada         (wb_entrada),
    .m_entrada          (m_entrada),
    .alu_result         (alu_result),
    .write_data         (write_data),
    .zero               (zero),
    .ex_mem_register_rd (ex_mem_register_rd),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_rdata         (dmem_rdata),
    .dmem_ack           (dmem_ack),
    .stall              (stall),
    .pc_src             (pc_src),
    .wb_salida          (wb_salida),
    .read_data          (read_data),
    .alu_out            (alu_out),
    .mem_wb_register_rd (mem_wb_register_rd),
    .mem_error          (mem_error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  task automatic checkMemWb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_wb"}, 32'(wb_salida), 32'(e.wb));
      checkOutput({tag, "_read_data"}, read_data, e.data);
      checkOutput({tag, "_alu_out"}, alu_out, e.alu);
      checkOutput({tag, "_rd"}, 32'(mem_wb_register_rd), 32'(e.rd));
    end
  endtask

  // Drive one instruction, play the memory side (ack_delay < 0 means never ack),
  // then compare the retired MEM/WB contents against the scoreboard.
  task automatic applyStimulus(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd, input int ack_delay,
                               input logic [31:0] rdata, input string tag);
    exp_t e;
    bit   is_mem;
    bit   is_wr;
    bit   mis;
    int   n;
    int   exp_stall;
    @(negedge clock);
    wb_entrada         = wb;
    m_entrada          = m;
    alu_result         = addr;
    write_data         = wdata;
    ex_mem_register_rd = rd;
    dmem_ack           = 1'b0;
    is_mem = m[1] | m[0];
    is_wr  = m[0];
    mis    = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = is_mem && (addr[1:0] != 2'b00);
`endif
    e.alu = addr;
    e.rd  = rd;
    if (!is_mem) begin
      e.wb = wb; e.data = 32'd0;
    end else if (mis) begin
      e.wb = 2'b00; e.data = 32'd0;
    end else begin
      e.wb   = {wb[1] & ~is_wr, wb[0]};
      e.data = (ack_delay < 0) ? 32'd0 : rdata;
    end
    sb.push_back(e);
    @(posedge clock);
    if (is_mem) begin
      @(negedge clock);
      if (mis) begin
        checkOutput({tag, "_no_req"}, 32'(dmem_req), 32'd0);
        checkOutput({tag, "_err"}, 32'(mem_error), 32'd1);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
      end else begin
        checkOutput({tag, "_req"}, 32'(dmem_req), 32'd1);
        checkOutput({tag, "_addr"}, dmem_addr, addr);
        checkOutput({tag, "_we"}, 32'(dmem_we), 32'(is_wr));
        checkOutput({tag, "_wdata"}, dmem_wdata, wdata);
        checkOutput({tag, "_wb_bubble"}, 32'(wb_salida), 32'd0);
        n = 0;
        while (stall && n < 300) begin
          if (n == ack_delay) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
          end
          @(posedge clock);
          @(negedge clock);
          dmem_ack   = 1'b0;
          dmem_rdata = 32'hBAD0BAD0;
          n++;
        end
        exp_stall = (ack_delay < 0) ? WAIT_MAX : ack_delay + 1;
        checkOutput({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        checkOutput({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
      end
      @(posedge clock);
    end
    @(negedge clock);
    checkMemWb(tag);
    m_entrada  = 3'b000;
    wb_entrada = 2'b00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    wb_entrada = '0; m_entrada = '0; alu_result = '0; write_data = '0;
    zero = 1'b0; ex_mem_register_rd = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    #1;
    checkOutput("rst_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_err", 32'(mem_error), 32'd0);
    checkOutput("rst_wb", 32'(wb_salida), 32'd0);
    checkOutput("rst_alu_out", alu_out, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(2'b10, 3'b000, 32'h0000_0055, 32'd0, 5'd3, 0, 32'd0, "alu_op");
    applyStimulus(2'b11, 3'b010, 32'h0000_0010, 32'd0, 5'd5, 3, 32'hDEAD_BEEF, "load_10");
    applyStimulus(2'b10, 3'b001, 32'h0000_0020, 32'h0000_1234, 5'd6, 0, 32'd0, "store_20");
    applyStimulus(2'b10, 3'b011, 32'h0000_0024, 32'h0000_5678, 5'd8, 1, 32'd0, "rw_as_store");
    checkOutput("err_clear_before_timeout", 32'(mem_error), 32'd0);
    applyStimulus(2'b11, 3'b010, 32'h0000_0030, 32'd0, 5'd12, -1, 32'd0, "load_timeout");
    checkOutput("timeout_err", 32'(mem_error), 32'd1);
    applyStimulus(2'b11, 3'b010, 32'h0000_0034, 32'd0, 5'd13, 2, 32'h0BAD_F00D, "load_after_to");
    checkOutput("err_sticky", 32'(mem_error), 32'd1);

    // Branch: pc_src follows branch & zero combinationally, no memory traffic.
    @(negedge clock);
    m_entrada = 3'b100; zero = 1'b1; wb_entrada = 2'b00;
    #1 checkOutput("pc_src_taken", 32'(pc_src), 32'd1);
    @(posedge clock);
    @(negedge clock);
    checkOutput("branch_no_req", 32'(dmem_req), 32'd0);
    zero = 1'b0;
    #1 checkOutput("pc_src_not_taken", 32'(pc_src), 32'd0);
    m_entrada = 3'b000;

    // Reset in the middle of a wait abandons the access.
    @(negedge clock);
    m_entrada = 3'b010; wb_entrada = 2'b11; alu_result = 32'h40; ex_mem_register_rd = 5'd7;
    repeat (2) @(negedge clock);
    checkOutput("mid_wait_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", 32'(dmem_req), 32'd0);
    checkOutput("mid_rst_stall", 32'(stall), 32'd0);
    checkOutput("mid_rst_err", 32'(mem_error), 32'd0);
    checkOutput("mid_rst_wb", 32'(wb_salida), 32'd0);
    checkOutput("mid_rst_alu_out", alu_out, 32'd0);
    checkOutput("mid_rst_rd", 32'(mem_wb_register_rd), 32'd0);
    m_entrada = 3'b000; wb_entrada = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(2'b11, 3'b010, 32'h0000_0044, 32'd0, 5'd9, 1, 32'h1357_9BDF, "load_post_rst");
    applyStimulus(2'b11, 3'b010, 32'h0000_0013, 32'd0, 5'd10, 0, 32'hCAFE_0013, "load_13");
`ifdef MEM_MISALIGN_CHECK_EN
    checkOutput("misalign_err", 32'(mem_error), 32'd1);
`else
    checkOutput("unaligned_no_err", 32'(mem_error), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
